sobel_frame_streamer: RTL and testbench

Transmit side of the edge-detection image path. Holds one 8-bit grayscale frame in an internal buffer, loaded through a simple write port. On a start pulse it streams the frame out in raster order (row 0 col 0 first) over a valid/ready pixel interface, with start-of-frame, end-of-line and end-of-frame markers. A Sobel stage or a file-dump bench sits downstream. Optional border zeroing matches the filter's one-pixel zero border.

---
 rtl/sobel_frame_streamer.sv | 192 +++++++++++++++++++
 tb/tb_sobel_frame_streamer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_frame_streamer.sv
// sobel_frame_streamer
//   Holds one 8-bit grayscale frame in an internal RAM and streams it out in
//   raster order over a valid/ready pixel interface. A start pulse launches
//   the stream. Optional zeroing of the one-pixel frame border.
//
// Ports
//   clk, rst           : clock, asynchronous active-high reset
//   wr_en/addr/data    : frame buffer write port (dropped while busy)
//   start              : one-cycle stream request (ignored while busy)
//   busy, done         : stream in progress / one-cycle completion pulse
//   m_valid, m_ready   : pixel handshake
//   m_data             : pixel value
//   m_sof/m_eol/m_eof  : start-of-frame, end-of-line, end-of-frame markers
//   m_row, m_col       : coordinates of the pixel on m_data
//
// Handshake: a pixel transfers on a rising edge where m_valid and m_ready are
// both high. Once m_valid is high, it and every m_* output hold their values
// until that transfer happens.
module sobel_frame_streamer #(
    parameter int ROWS        = 242,
    parameter int COLS        = 247,
    parameter int ADDR_W      = 16,
    parameter int ZERO_BORDER = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [7:0]        m_data,
    output logic              m_sof,
    output logic              m_eol,
    output logic              m_eof,
    output logic [15:0]       m_row,
    output logic [15:0]       m_col
);
    localparam int NPIX  = ROWS * COLS;
    localparam int IDX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
    localparam logic [15:0] LAST_ROW = 16'(ROWS - 1);
    localparam logic [15:0] LAST_COL = 16'(COLS - 1);

    typedef enum logic [1:0] {IDLE, PRIME, STREAM, DONE} state_t;

    typedef struct packed {
        logic [7:0]  data;
        logic        sof;
        logic        eol;
        logic        eof;
        logic [15:0] row;
        logic [15:0] col;
    } beat_t;

    state_t state, state_nxt;

    logic [7:0] mem [NPIX];
    logic [7:0] rdata;

    // Read side: next address to fetch and its coordinates
    logic [ADDR_W-1:0] rd_addr;
    logic [15:0]       rd_row, rd_col;
    logic              rd_all;

    // Metadata of the read in flight (RAM data appears one cycle later)
    logic        pend_valid, pend_zero, pend_sof, pend_eol, pend_eof;
    logic [15:0] pend_row, pend_col;

    beat_t out_q, skid_q, in_beat;
    logic  skid_valid;

    logic       pop, launch, issue;
    logic [1:0] occ;

    assign busy   = (state == PRIME) || (state == STREAM);
    assign done   = (state == DONE);
    assign pop    = m_valid && m_ready;
    assign launch = start && ((state == IDLE) || (state == DONE));

    // Entries held after this edge (output + skid + landing read). A new read
    // is issued only if its data is guaranteed a slot even if nothing pops.
    assign occ   = 2'(m_valid) + 2'(skid_valid) + 2'(pend_valid) - 2'(pop);
    assign issue = busy && !rd_all && (occ < 2'd2);

    assign in_beat = {(pend_zero ? 8'd0 : rdata), pend_sof, pend_eol, pend_eof,
                      pend_row, pend_col};

    assign m_data = out_q.data;
    assign m_sof  = out_q.sof;
    assign m_eol  = out_q.eol;
    assign m_eof  = out_q.eof;
    assign m_row  = out_q.row;
    assign m_col  = out_q.col;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = PRIME;
            PRIME:   state_nxt = STREAM;
            STREAM:  if (pop && m_eof) state_nxt = DONE;
            DONE:    state_nxt = start ? PRIME : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Frame buffer: no reset; writes locked out while streaming
    always_ff @(posedge clk) begin
        if (wr_en && !busy && (32'(wr_addr) < NPIX))
            mem[wr_addr[IDX_W-1:0]] <= wr_data;
        if (issue)
            rdata <= mem[rd_addr[IDX_W-1:0]];
    end

    // Read pointer and in-flight metadata
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_addr    <= '0;
            rd_row     <= '0;
            rd_col     <= '0;
            rd_all     <= 1'b0;
            pend_valid <= 1'b0;
            pend_zero  <= 1'b0;
            pend_sof   <= 1'b0;
            pend_eol   <= 1'b0;
            pend_eof   <= 1'b0;
            pend_row   <= '0;
            pend_col   <= '0;
        end else begin
            pend_valid <= issue;
            if (launch) begin
                rd_addr <= '0;
                rd_row  <= '0;
                rd_col  <= '0;
                rd_all  <= 1'b0;
            end else if (issue) begin
                pend_zero <= (ZERO_BORDER != 0) &&
                             (rd_row == 16'd0 || rd_row == LAST_ROW ||
                              rd_col == 16'd0 || rd_col == LAST_COL);
                pend_sof  <= (rd_row == 16'd0) && (rd_col == 16'd0);
                pend_eol  <= (rd_col == LAST_COL);
                pend_eof  <= (rd_row == LAST_ROW) && (rd_col == LAST_COL);
                pend_row  <= rd_row;
                pend_col  <= rd_col;
                // Pointer parks on the last address; rd_all blocks further reads
                if (rd_addr == LAST_ADDR) rd_all  <= 1'b1;
                else                      rd_addr <= rd_addr + 1'b1;
                if (rd_col == LAST_COL) begin
                    rd_col <= '0;
                    rd_row <= rd_row + 16'd1;
                end else begin
                    rd_col <= rd_col + 16'd1;
                end
            end
        end
    end

    // Output register plus skid entry; the skid always holds the older beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid    <= 1'b0;
            out_q      <= '0;
            skid_valid <= 1'b0;
            skid_q     <= '0;
        end else if (pop) begin
            if (skid_valid) begin
                out_q      <= skid_q;
                skid_valid <= pend_valid;
                if (pend_valid) skid_q <= in_beat;
            end else begin
                m_valid <= pend_valid;
                if (pend_valid) out_q <= in_beat;
            end
        end else if (m_valid) begin
            if (pend_valid) begin
                skid_valid <= 1'b1;
                skid_q     <= in_beat;
            end
        end else begin
            m_valid <= pend_valid;
            if (pend_valid) out_q <= in_beat;
        end
    end
endmodule

// File: tb/tb_sobel_frame_streamer.sv
// Bench for sobel_frame_streamer. Three instances: 3x4 plain, 3x4 with border
// zeroing, 1x1. A frame model builds the expected raster sequence at start.
module tb_sobel_frame_streamer;
    localparam int N = 3;
    localparam int W = 43;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        wr_en   [N];
    logic [15:0] wr_addr [N];
    logic [7:0]  wr_data [N];
    logic        start   [N];
    logic        busy    [N];
    logic        done    [N];
    logic        m_valid [N];
    logic        m_ready [N];
    logic [7:0]  m_data  [N];
    logic        m_sof   [N];
    logic        m_eol   [N];
    logic        m_eof   [N];
    logic [15:0] m_row   [N];
    logic [15:0] m_col   [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        sobel_frame_streamer #(
            .ROWS(g == 2 ? 1 : 3), .COLS(g == 2 ? 1 : 4),
            .ADDR_W(16), .ZERO_BORDER(g == 1 ? 1 : 0)
        ) u_dut (
            .clk(clk), .rst(rst),
            .wr_en(wr_en[g]), .wr_addr(wr_addr[g]), .wr_data(wr_data[g]),
            .start(start[g]), .busy(busy[g]), .done(done[g]),
            .m_valid(m_valid[g]), .m_ready(m_ready[g]), .m_data(m_data[g]),
            .m_sof(m_sof[g]), .m_eol(m_eol[g]), .m_eof(m_eof[g]),
            .m_row(m_row[g]), .m_col(m_col[g])
        );
    end

    function automatic int rows_of(input int i); return (i == 2) ? 1 : 3; endfunction
    function automatic int cols_of(input int i); return (i == 2) ? 1 : 4; endfunction
    function automatic bit zb_of(input int i);   return (i == 1);         endfunction

    // ---------------- model / scoreboard state ----------------
    logic [7:0]   model_mem [N][12];
    logic [W-1:0] exp_q     [N][$];
    logic [7:0]   obs_q     [N][$];
    logic         model_busy[N];
    logic         done_exp  [N];
    logic         prev_stall[N];
    logic [W-1:0] prev_beat [N];
    int           xfer_cnt  [N];
    int           done_cnt  [N];
    int           rdy_mode  [N];
    int           rdy_ph    [N];
    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] lit_a   [12];
    logic [7:0] lit_zb  [12];
    logic [7:0] lit_one [12];

    task automatic chk1(input logic act, input logic exp, input string nm, input int i);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s inst%0d: got %b expected %b (t=%0t)", nm, i, act, exp, $time);
        end
    endtask

    task automatic chkw(input logic [W-1:0] act, input logic [W-1:0] exp, input string nm, input int i);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s inst%0d: got data=%0d sof=%b eol=%b eof=%b row=%0d col=%0d expected data=%0d sof=%b eol=%b eof=%b row=%0d col=%0d (t=%0t)",
                     nm, i, act[42:35], act[34], act[33], act[32], act[31:16], act[15:0],
                     exp[42:35], exp[34], exp[33], exp[32], exp[31:16], exp[15:0], $time);
        end
    endtask

    task automatic chk_int(input int act, input int exp, input string nm, input int i);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s inst%0d: got %0d expected %0d", nm, i, act, exp);
        end
    endtask

    // Expected frame from the raster-order definition
    task automatic build_expected(input int i);
        int r, c;
        logic [7:0] d;
        bit bord;
        for (r = 0; r < rows_of(i); r++)
            for (c = 0; c < cols_of(i); c++) begin
                bord = zb_of(i) && (r == 0 || r == rows_of(i) - 1 || c == 0 || c == cols_of(i) - 1);
                d = bord ? 8'd0 : model_mem[i][r * cols_of(i) + c];
                exp_q[i].push_back({d, 1'(r == 0 && c == 0), 1'(c == cols_of(i) - 1),
                                    1'(r == rows_of(i) - 1 && c == cols_of(i) - 1),
                                    16'(r), 16'(c)});
            end
    endtask

    // ---------------- compare process ----------------
    task automatic check_cycle(input int i);
        logic [W-1:0] act, e;
        act = {m_data[i], m_sof[i], m_eol[i], m_eof[i], m_row[i], m_col[i]};
        chk1(busy[i], model_busy[i], "busy", i);
        chk1(done[i], done_exp[i], "done", i);
        if (done[i]) done_cnt[i]++;
        done_exp[i] = 1'b0;
        if (prev_stall[i]) begin
            chk1(m_valid[i], 1'b1, "hold_valid", i);
            chkw(act, prev_beat[i], "hold_beat", i);
        end
        if (m_valid[i] && m_ready[i]) begin
            if (exp_q[i].size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL extra_beat inst%0d: got data=%0d expected no pixel", i, m_data[i]);
            end else begin
                e = exp_q[i].pop_front();
                chkw(act, e, "beat", i);
                obs_q[i].push_back(m_data[i]);
                xfer_cnt[i]++;
                if (exp_q[i].size() == 0) begin
                    model_busy[i] = 1'b0;
                    done_exp[i]   = 1'b1;
                end
            end
        end
        prev_stall[i] = m_valid[i] && !m_ready[i];
        prev_beat[i]  = act;
    endtask

    always @(negedge clk) begin
        if (!rst)
            for (int i = 0; i < N; i++) check_cycle(i);
    end

    // Ready driver: mode 0 = always ready, mode 1 = pattern 1,0,0 repeating
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N; i++) begin
            m_ready[i] = (rdy_mode[i] == 0) ? 1'b1 : (rdy_ph[i] % 3 == 0);
            rdy_ph[i]++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic write_px(input int i, input int addr, input logic [7:0] data);
        @(posedge clk); #1;
        wr_en[i] = 1'b1; wr_addr[i] = 16'(addr); wr_data[i] = data;
        @(posedge clk); #1;
        wr_en[i] = 1'b0;
        if (!model_busy[i] && addr < rows_of(i) * cols_of(i))
            model_mem[i][addr] = data;
    endtask

    task automatic start_stream(input int i);
        @(posedge clk); #1;
        start[i] = 1'b1;
        @(posedge clk); #1;
        start[i] = 1'b0;
        if (!model_busy[i]) begin
            model_busy[i] = 1'b1;
            build_expected(i);
        end
    endtask

    task automatic wait_idle(input int i);
        int b = 0;
        while (model_busy[i] && b < 300) begin
            @(negedge clk);
            b++;
        end
        if (model_busy[i]) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout inst%0d: got %0d pixels left expected 0", i, exp_q[i].size());
            exp_q[i].delete();
            model_busy[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_obs(input int i, input int n, input logic [7:0] lit[12], input string nm);
        chk_int(obs_q[i].size(), n, {nm, "_count"}, i);
        for (int k = 0; k < n && k < obs_q[i].size(); k++)
            chk_int(int'(obs_q[i][k]), int'(lit[k]), nm, i);
    endtask

    // Streams one frame; with gapless=1 also checks the 2-cycle start latency
    // and one pixel per cycle with m_ready held high.
    task automatic run_stream(input int i, input int n, input logic [7:0] lit[12],
                              input bit gapless, input string nm);
        int d0;
        obs_q[i].delete();
        d0 = done_cnt[i];
        start_stream(i);
        if (gapless) begin
            @(negedge clk); chk1(m_valid[i], 1'b0, "lat_edge1", i);
            @(negedge clk); chk1(m_valid[i], 1'b0, "lat_edge2", i);
            for (int k = 0; k < n; k++) begin
                @(negedge clk); chk1(m_valid[i], 1'b1, "no_gap", i);
            end
        end
        wait_idle(i);
        check_obs(i, n, lit, nm);
        chk_int(done_cnt[i] - d0, 1, "done_pulses", i);
    endtask

    task automatic apply_reset_checks(input int i);
        chk1(m_valid[i], 1'b0, "rst_valid", i);
        chk1(busy[i], 1'b0, "rst_busy", i);
        chk1(done[i], 1'b0, "rst_done", i);
        chkw({m_data[i], m_sof[i], m_eol[i], m_eof[i], m_row[i], m_col[i]}, '0, "rst_outputs", i);
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) begin
            exp_q[i].delete();
            model_busy[i] = 1'b0;
            done_exp[i]   = 1'b0;
            prev_stall[i] = 1'b0;
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int b;
        for (int i = 0; i < N; i++) begin
            wr_en[i] = 1'b0; wr_addr[i] = '0; wr_data[i] = '0; start[i] = 1'b0;
            m_ready[i] = 1'b1; rdy_mode[i] = 0; rdy_ph[i] = 0;
            xfer_cnt[i] = 0; done_cnt[i] = 0;
            for (int k = 0; k < 12; k++) model_mem[i][k] = '0;
        end
        clear_model();
        for (int k = 0; k < 12; k++) lit_a[k] = 8'(10 + k);
        lit_zb = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd15, 8'd16, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        lit_one = '{8'd7, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};

        #1 rst = 1'b1;
        #10;
        for (int i = 0; i < N; i++) apply_reset_checks(i);
        #11 rst = 1'b0;

        // Load frames: value 10+k at address k; single-pixel frame holds 7
        for (int k = 0; k < 12; k++) begin
            write_px(0, k, 8'(10 + k));
            write_px(1, k, 8'(10 + k));
        end
        write_px(2, 0, 8'd7);
        write_px(2, 1, 8'd99);   // out of range, must be dropped

        run_stream(0, 12, lit_a, 1'b1, "plain");
        run_stream(1, 12, lit_zb, 1'b1, "zero_border");
        run_stream(2, 1, lit_one, 1'b1, "single");

        // Back-pressure: ready 1,0,0,...
        rdy_mode[0] = 1;
        run_stream(0, 12, lit_a, 1'b0, "stalled");
        rdy_mode[0] = 0;

        // Start and write while streaming must both be ignored
        obs_q[0].delete();
        start_stream(0);
        repeat (3) @(negedge clk);
        write_px(0, 5, 8'd99);
        start_stream(0);
        wait_idle(0);
        check_obs(0, 12, lit_a, "busy_ignore");
        run_stream(0, 12, lit_a, 1'b1, "after_drop");

        // Reset mid-stream after 6 transfers, then restart from (0,0)
        obs_q[0].delete();
        start_stream(0);
        b = 0;
        while (xfer_cnt[0] < 6 * 0 + xfer_cnt[0] - obs_q[0].size() + 6 && b < 100) begin
            @(negedge clk);
            b++;
        end
        chk_int(obs_q[0].size(), 6, "pre_reset_xfers", 0);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        apply_reset_checks(0);
        clear_model();
        @(posedge clk); #2;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk1(done[0], 1'b0, "no_done_after_abort", 0);
        run_stream(0, 12, lit_a, 1'b1, "after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before 500000");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end
endmodule
